// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package ifu_fetch_pkg;

  localparam logic [31:0] TEXT_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DROP  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_e;

  // Saturating 32-bit increment for the stall counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifu_addr_check.sv
// PC range/alignment check and ROM word-address generation (combinational).
module ifu_addr_check
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE   = TEXT_BASE_DEF,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10
) (
  input  logic [31:0]   pc,
  output logic          addr_ok,
  output logic [AW-1:0] word_addr
);

  localparam logic [31:0] TEXT_BYTES = 32'(DEPTH_WORDS) << 2;

  logic [31:0] off;

  // Byte offset into the text segment; only meaningful when pc >= TEXT_BASE.
  assign off       = pc - TEXT_BASE;
  assign addr_ok   = (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && (off < TEXT_BYTES);
  assign word_addr = off[AW+1:2];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: one outstanding ROM read, decode-side valid/ready,
// PC hold control, sticky fault on bad PC, and a saturating stall counter.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE   = TEXT_BASE_DEF,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  input  logic          flush,
  output logic          pc_hold,
  output logic [31:0]   instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          fault,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   wait_cycles
);

  fetch_state_e state, state_nxt;
  logic         addr_ok;
  logic [AW-1:0] word_addr;
  logic         ld_instr;
  logic         stall_cnt_en;

  ifu_addr_check #(
    .TEXT_BASE  (TEXT_BASE),
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_addr_check (
    .pc       (pc),
    .addr_ok  (addr_ok),
    .word_addr(word_addr)
  );

  assign mem_addr     = word_addr;
  assign instr_valid  = (state == ST_VALID);
  assign fault        = (state == ST_FAULT);
  assign pc_hold      = !(instr_valid && instr_ready) && !flush;
  assign stall_cnt_en = pc_hold &&
                        ((state == ST_REQ) || (state == ST_WAIT) || (state == ST_DROP));

  // Next-state and request/load decode.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    ld_instr  = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (addr_ok) begin
          mem_req = 1'b1;
          if (mem_ack) state_nxt = flush ? ST_DROP : ST_WAIT;
        end else if (!flush) begin
          // A flush here means the PC is about to load a new target, so the
          // bad address is re-evaluated next cycle instead of faulting.
          state_nxt = ST_FAULT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_nxt = mem_rvalid ? ST_REQ : ST_DROP;
        end else if (mem_rvalid) begin
          ld_instr  = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: if (instr_ready || flush) state_nxt = ST_REQ;
      ST_DROP:  if (mem_rvalid) state_nxt = ST_REQ;
      ST_FAULT: if (flush) state_nxt = ST_REQ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Instruction register: loaded only by the response to a live fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instr <= NOP_WORD;
    else if (ld_instr) instr <= mem_rdata;
  end

  // Stall counter: cycles the PC is frozen waiting on the ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             wait_cycles <= 32'd0;
    else if (stall_cnt_en) wait_cycles <= sat_inc32(wait_cycles);
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: PC register + ROM behavioural models, directed scenarios
// followed by randomized fetch/jump/backpressure traffic.
module tb_ifu_fetch;

  localparam logic [31:0] TB_BASE = 32'h0000_3000;
  localparam int          DEPTH   = 1024;
  localparam int          AW      = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc;
  logic          flush;
  logic          pc_hold;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          fault;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic [31:0]   wait_cycles;

  always #5 clk = ~clk;

  ifu_fetch #(.TEXT_BASE(TB_BASE), .DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush), .pc_hold(pc_hold),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fault(fault), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wait_cycles(wait_cycles)
  );

  logic [31:0] rom [DEPTH];
  int total = 0, passed = 0;

  // Bench-side models and knobs
  logic [31:0]   pc_r, flush_tgt, last_tgt, poison, prev_instr;
  logic          ready, flush_now, last_hold, last_flush, poison_en, pend_valid, prev_hold_valid;
  int            ack_lat, rv_lat, req_cnt, pend_cnt, accepted;
  logic [AW-1:0] pend_addr;

  function automatic logic bad_pc(input logic [31:0] p);
    longint unsigned lp;
    lp = longint'(p);
    return (p % 4 != 0) || (lp < longint'(TB_BASE)) || (lp >= longint'(TB_BASE) + 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] p);
    return int'((p - TB_BASE) / 4) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock: update PC register, play ROM, then check global rules.
  task automatic cyc();
    @(posedge clk); #1;
    if (last_flush)      pc_r = last_tgt;
    else if (!last_hold) pc_r = pc_r + 32'd4;
    pc = pc_r; flush = flush_now; instr_ready = ready;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    if (pend_valid) begin
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = poison_en ? poison : rom[pend_addr];
        pend_valid = 1'b0; poison_en = 1'b0;
      end else pend_cnt--;
    end
    #1;
    if (mem_req) begin
      chk("mem_addr", 32'(mem_addr), 32'(widx(pc)));
      chk("req_pc_ok", 32'(bad_pc(pc)), 32'd0);
      if (req_cnt >= ack_lat) begin
        chk("one_outstanding", 32'(pend_valid), 32'd0);
        mem_ack = 1'b1; pend_valid = 1'b1; pend_cnt = rv_lat - 1;
        pend_addr = mem_addr; req_cnt = 0;
      end else req_cnt++;
      if (flush && !mem_ack) req_cnt = 0;
    end else req_cnt = 0;
    #1;
    if (fault) chk("fault_pc_bad", 32'(bad_pc(pc)), 32'd1);
    chk("pc_hold_rule", 32'(pc_hold), 32'(!(instr_valid && instr_ready) && !flush));
    if (prev_hold_valid) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, prev_instr);
    end
    if (instr_valid && instr_ready) begin
      chk("instr_word", instr, rom[widx(pc)]);
      accepted++;
    end
    prev_hold_valid = instr_valid && !instr_ready && !flush;
    prev_instr = instr;
    last_hold = pc_hold; last_flush = flush; last_tgt = flush_tgt;
  endtask

  // Reset DUT and ROM together; returns in cycle 0 (IDLE) with pc = p0.
  task automatic do_reset(input logic [31:0] p0);
    reset = 1'b1;
    pend_valid = 1'b0; req_cnt = 0; flush_now = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; poison_en = 1'b0;
    prev_hold_valid = 1'b0; ready = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pc_r = p0; pc = p0; last_hold = 1'b1; last_flush = 1'b0; reset = 1'b0;
    #2;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h2408_0001;
    ack_lat = 0; rv_lat = 1; flush_tgt = TB_BASE; last_tgt = TB_BASE; poison = 32'h0;
    accepted = 0; prev_instr = 32'h0; pend_cnt = 0; pend_addr = '0;

    // 1: zero-wait ROM, first fetch latency
    do_reset(32'h3000);
    chk("t1_rst_req",   32'(mem_req), 32'd0);
    chk("t1_rst_valid", 32'(instr_valid), 32'd0);
    chk("t1_rst_instr", instr, 32'h0);
    chk("t1_rst_fault", 32'(fault), 32'd0);
    chk("t1_rst_wait",  wait_cycles, 32'd0);
    cyc(); chk("t1_req", 32'(mem_req), 32'd1); chk("t1_addr", 32'(mem_addr), 32'd0);
    cyc(); chk("t1_c2_valid", 32'(instr_valid), 32'd0);
    cyc(); chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h2408_0001);
    chk("t1_wait", wait_cycles, 32'd2);

    // 2: slow ack (3 cycles) and rvalid 2 cycles after ack
    do_reset(32'h3004); ack_lat = 3; rv_lat = 2; ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk("t2_hold", 32'(pc_hold), 32'd1);
      chk("t2_notvalid", 32'(instr_valid), 32'd0);
      if (c <= 4) chk("t2_req", 32'(mem_req), 32'd1);
    end
    cyc(); chk("t2_valid", 32'(instr_valid), 32'd1); chk("t2_wait", wait_cycles, 32'd6);

    // 3: decode backpressure in VALID
    do_reset(32'h3000); ack_lat = 0; rv_lat = 1; ready = 1'b0;
    repeat (3) cyc();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_instr", instr, rom[0]);
      chk("t3_hold", 32'(pc_hold), 32'd1);
    end
    ready = 1'b1; cyc(); chk("t3_release", 32'(pc_hold), 32'd0);
    ready = 1'b0; cyc();
    chk("t3_next_req", 32'(mem_req), 32'd1); chk("t3_next_addr", 32'(mem_addr), 32'd1);
    cyc(); chk("t3_hold_again", 32'(pc_hold), 32'd1);

    // 4: flush in WAIT before rvalid; late poisoned data must be dropped
    do_reset(32'h3000); ack_lat = 0; rv_lat = 4; ready = 1'b1;
    cyc();
    flush_now = 1'b1; flush_tgt = 32'h3010; poison = 32'hDEAD_BEEF; poison_en = 1'b1;
    cyc(); chk("t4_flush_release", 32'(pc_hold), 32'd0);
    flush_now = 1'b0; rv_lat = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_drop_noreq", 32'(mem_req), 32'd0);
      chk("t4_drop_notvalid", 32'(instr_valid), 32'd0);
      chk("t4_no_stale", 32'(instr == 32'hDEAD_BEEF), 32'd0);
    end
    cyc(); chk("t4_tgt_req", 32'(mem_req), 32'd1); chk("t4_tgt_addr", 32'(mem_addr), 32'd4);
    cyc();
    cyc(); chk("t4_valid", 32'(instr_valid), 32'd1); chk("t4_instr", instr, rom[4]);
    chk("t4_wait", wait_cycles, 32'd6);

    // 6: asynchronous reset mid-cycle while in WAIT
    rv_lat = 3;
    cyc(); chk("t6_req", 32'(mem_req), 32'd1); chk("t6_addr", 32'(mem_addr), 32'd5);
    cyc(); chk("t6_wait_state", 32'(mem_req), 32'd0);
    #2; reset = 1'b1; #1;
    chk("t6_rst_req",   32'(mem_req), 32'd0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", instr, 32'h0);
    chk("t6_rst_fault", 32'(fault), 32'd0);
    chk("t6_rst_wait",  wait_cycles, 32'd0);
    chk("t6_rst_hold",  32'(pc_hold), 32'd1);
    do_reset(32'h3020); ack_lat = 0; rv_lat = 1; ready = 1'b1;
    chk("t6_idle_noreq", 32'(mem_req), 32'd0);
    cyc(); chk("t6_restart_req", 32'(mem_req), 32'd1); chk("t6_restart_addr", 32'(mem_addr), 32'd8);
    cyc(); cyc(); chk("t6_restart_valid", 32'(instr_valid), 32'd1);

    // 5: misaligned / below-range PC faults; flush recovers
    do_reset(32'h3002); ready = 1'b0;
    cyc(); chk("t5_noreq", 32'(mem_req), 32'd0);
    cyc(); chk("t5_fault", 32'(fault), 32'd1); chk("t5_fault_noreq", 32'(mem_req), 32'd0);
    chk("t5_fault_hold", 32'(pc_hold), 32'd1);
    flush_now = 1'b1; flush_tgt = 32'h2FFC; cyc(); flush_now = 1'b0;
    cyc(); chk("t5_low_noreq", 32'(mem_req), 32'd0);
    repeat (4) cyc();
    chk("t5_low_fault_sticky", 32'(fault), 32'd1); chk("t5_low_noreq2", 32'(mem_req), 32'd0);
    flush_now = 1'b1; flush_tgt = 32'h4000; cyc(); flush_now = 1'b0;
    cyc(); cyc(); chk("t5_high_fault", 32'(fault), 32'd1);
    flush_now = 1'b1; flush_tgt = 32'h3000; cyc(); flush_now = 1'b0;
    cyc(); chk("t5_clear", 32'(fault), 32'd0);
    chk("t5_req", 32'(mem_req), 32'd1); chk("t5_addr", 32'(mem_addr), 32'd0);

    // last ROM word, then sequential advance off the end
    do_reset(32'h3FFC); ready = 1'b0;
    cyc(); chk("edge_req", 32'(mem_req), 32'd1); chk("edge_addr", 32'(mem_addr), 32'd1023);
    cyc(); ready = 1'b1;
    cyc(); chk("edge_valid", 32'(instr_valid), 32'd1);
    ready = 1'b0;
    cyc(); chk("edge_past_noreq", 32'(mem_req), 32'd0);
    cyc(); chk("edge_past_fault", 32'(fault), 32'd1);

    // randomized traffic: ROM latencies, backpressure, jumps
    do_reset(32'h3000); accepted = 0;
    for (int n = 0; n < 800; n++) begin
      ack_lat   = int'($urandom_range(0, 2));
      rv_lat    = int'($urandom_range(1, 3));
      ready     = ($urandom_range(0, 1) == 1);
      flush_now = ($urandom_range(0, 7) == 0);
      flush_tgt = TB_BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      cyc();
    end
    chk("rand_progress", 32'(accepted > 20), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
